// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode enum and default
// sizing/threshold constants.
package sync_fifo_pkg;

    // FIFO_FWFT: head of queue is shown combinationally on rd_data.
    // FIFO_REG : rd_data is registered on an accepted read, valid for one cycle.
    typedef enum logic {
        FIFO_FWFT = 1'b0,
        FIFO_REG  = 1'b1
    } fifo_rd_mode_e;

    localparam int unsigned DEF_DSIZE     = 8;
    localparam int unsigned DEF_ASIZE     = 4;
    localparam int unsigned DEF_AEMPTY_TH = 2;

    // Default almost-full threshold: two entries short of full.
    function automatic int unsigned def_afull_th(input int unsigned asize);
        return (32'd1 << asize) - 32'd2;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: DEPTH x DSIZE, one synchronous write port and one
// asynchronous read port. Contents are cleared by the asynchronous reset.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   we           write enable
//   waddr        write address
//   wdata        write data
//   raddr        read address
//   rdata        read data (combinational from raddr)
module fifo_mem_2p #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow flags, synchronous flush and a selectable
// first-word-fall-through or registered read port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous clear of pointers and count
//   clr_err                    clears overflow/underflow
//   wr_en, wr_data             write request and data
//   wr_full, wr_almost_full    write-side status
//   rd_en, rd_data, rd_valid   read request, data and data-valid
//   rd_empty, rd_almost_empty  read-side status
//   count                      occupancy, 0..DEPTH
//   overflow, underflow        sticky error flags
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int unsigned   DSIZE     = DEF_DSIZE,
    parameter int unsigned   ASIZE     = DEF_ASIZE,
    parameter int unsigned   AFULL_TH  = def_afull_th(ASIZE),
    parameter int unsigned   AEMPTY_TH = DEF_AEMPTY_TH,
    parameter fifo_rd_mode_e RD_MODE   = FIFO_FWFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_err,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    output logic             wr_full,
    output logic             wr_almost_full,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_empty,
    output logic             rd_almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DEPTH = 32'd1 << ASIZE;
    localparam int unsigned CW    = ASIZE + 1;

    localparam logic [ASIZE:0] DepthC  = CW'(DEPTH);
    localparam logic [ASIZE:0] AFullC  = CW'(AFULL_TH);
    localparam logic [ASIZE:0] AEmptyC = CW'(AEMPTY_TH);

    if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH) begin : g_bad_threshold
        $error("sync_fifo_ext: AFULL_TH must be <= DEPTH and AEMPTY_TH < DEPTH");
    end

    logic [ASIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, underflow_q;
    logic             wr_acc, rd_acc;
    logic             ovf_set, unf_set;
    logic [DSIZE-1:0] mem_rdata;

    // Status flags are a pure function of the registered count.
    always_comb begin
        wr_full         = (count_q == DepthC);
        rd_empty        = (count_q == '0);
        wr_almost_full  = (count_q >= AFullC);
        rd_almost_empty = (count_q <= AEmptyC);
    end

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle; a read from an empty FIFO is never accepted.
    assign rd_acc  = rd_en && !rd_empty && !flush;
    assign wr_acc  = wr_en && (!wr_full || rd_acc) && !flush;
    assign ovf_set = wr_en && !wr_acc && !flush;
    assign unf_set = rd_en && !rd_acc && !flush;
    assign count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + ASIZE'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + ASIZE'(1);
            count_q <= count_d;
        end
    end

    // Sticky errors: a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set)               overflow_q <= 1'b1;
            else if (clr_err || flush) overflow_q <= 1'b0;
            if (unf_set)               underflow_q <= 1'b1;
            else if (clr_err || flush) underflow_q <= 1'b0;
        end
    end

    fifo_mem_2p #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (RD_MODE == FIFO_REG) begin : g_reg_read
        logic [DSIZE-1:0] rd_data_q;
        logic             rd_valid_q;

        // rd_valid is a one-cycle strobe following each accepted read;
        // rd_data keeps the last popped word until the next one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem_rdata;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        assign rd_data  = mem_rdata;
        assign rd_valid = !rd_empty;
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth DEPTH = 2**ASIZE.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries.
REQ-005 SHALL have parameter RD_MODE, default FIFO_FWFT, read mode (FIFO_FWFT or FIFO_REG).
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports listed in this order: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-007 SHALL have port flush input 1: synchronous clear of contents.
REQ-008 SHALL have port clr_err input 1: clears the sticky error flags.
REQ-009 SHALL have ports wr_en input 1 write request; wr_data input DSIZE write data.
REQ-010 SHALL have ports wr_full output 1 and wr_almost_full output 1.
REQ-011 SHALL have ports rd_en input 1 read request; rd_data output DSIZE; rd_valid output 1.
REQ-012 SHALL have ports rd_empty output 1 and rd_almost_empty output 1.
REQ-013 SHALL have port count output ASIZE+1: current occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow output 1 and underflow output 1: sticky error flags.

Function
REQ-015 SHALL define wr_acc = wr_en && (!wr_full || rd_acc) && !flush, and rd_acc = rd_en && !rd_empty && !flush.
REQ-016 SHALL, on full with a simultaneous write and read, accept both; count stays at DEPTH.
REQ-017 SHALL, on empty with a simultaneous write and read, accept the write, reject the read and set underflow.
REQ-018 SHALL store wr_data at wr_ptr on wr_acc and advance wr_ptr modulo DEPTH.
REQ-019 SHALL advance rd_ptr modulo DEPTH on rd_acc.
REQ-020 SHALL update count as count + wr_acc - rd_acc each cycle, registered.
REQ-021 SHALL drive combinational flags from count: wr_full = (count == DEPTH), rd_empty = (count == 0), wr_almost_full = (count >= AFULL_TH), rd_almost_empty = (count <= AEMPTY_TH).
REQ-022 SHALL, in FIFO_FWFT mode, drive rd_data = mem[rd_ptr] combinationally and rd_valid = !rd_empty.
REQ-023 SHALL, in FIFO_REG mode, register mem[rd_ptr] into rd_data on rd_acc and assert rd_valid for exactly the following cycle; otherwise rd_data holds its value.
REQ-024 SHALL set overflow when wr_en && !wr_acc && !flush, and set underflow when rd_en && !rd_acc && !flush; both hold until cleared.
REQ-025 SHALL, on flush, zero wr_ptr, rd_ptr and count and drop rd_valid next cycle, ignoring that cycle's wr_en/rd_en; memory contents need not be cleared.
REQ-026 SHALL clear overflow and underflow on clr_err or flush; a set and a clear in the same cycle SHALL result in set.
REQ-027 SHALL add no latency beyond REQ-022 and REQ-023: a write is visible on rd_empty and count the next cycle.

Reset
REQ-028 SHALL, on rst_n low and asynchronously, reset wr_ptr, rd_ptr and count to 0; memory to 0; rd_data register to 0; rd_valid, overflow and underflow to 0.
REQ-029 SHALL, immediately after reset, present rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0 and rd_data=0.
REQ-030 SHALL, on reset asserted mid-operation, abandon in-flight data with no partial writes.

Structure
REQ-031 SHALL take the enum fifo_rd_mode_e {FIFO_FWFT, FIFO_REG} and default depth/threshold constants from shared package sync_fifo_pkg.
REQ-032 SHALL place storage in sub-module fifo_mem_2p (DEPTH x DSIZE, one write port, one asynchronous read port), with pointer, count and flag logic in the top module.
REQ-033 SHALL reject AFULL_TH > DEPTH or AEMPTY_TH >= DEPTH at elaboration.

Verification
REQ-034 SHALL cover fill/drain (DSIZE=8, ASIZE=4): write 0x00..0x0F -> wr_full=1 and count=16 after the 16th; read 16 -> data 0x00..0x0F in order, rd_empty=1.
REQ-035 SHALL cover thresholds: count 13 gives wr_almost_full=0; count 14 gives 1; count 2 gives rd_almost_empty=1; count 3 gives 0.
REQ-036 SHALL cover full plus simultaneous read/write: at count=16, write 0xAA with rd_en -> count stays 16, overflow=0, and 0xAA is read 16th.
REQ-037 SHALL cover errors: write when full without read -> overflow=1, count unchanged; read when empty -> underflow=1; clr_err -> both 0.
REQ-038 SHALL cover FIFO_REG mode: write 0x5A, rd_en at cycle N -> rd_valid=1 and rd_data=0x5A at N+1 only.
REQ-039 SHALL cover flush and reset: flush with wr_en at count=7 -> count=0, rd_empty=1, write dropped; rst_n low mid-burst -> all REQ-029 values immediately.
